// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg
//   Shared constants for the memory-mapped down-counter timer: register
//   offsets inside the 4-word window, CTRL bit positions and the default
//   base address of the window.
package mmio_timer_pkg;

  // Register offsets (address - BASE).
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LOAD   = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // CTRL bit indices.
  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQEN      = 2;
  localparam int CTRL_W          = 3;

  // STATUS bit index.
  localparam int STATUS_EXPIRED  = 0;

  // Default window base; must be 4-aligned.
  localparam logic [7:0] DEFAULT_BASE = 8'hF0;

endpackage

// File: rtl/mmio_timer_if.sv
// mmio_timer_if
//   CPU memory-bus signals shared by the RAM block and the timer.
//   Signals:
//     address  - bus address from the CU
//     datain   - write data from the CU
//     dataout  - read data from the timer (0 unless read & hit)
//     read     - level read strobe
//     write    - level write strobe
//     hit      - address falls inside the timer window
//     irq      - expired & irqen
//
//   Bus protocol: there is no valid/ready pair. read and write are level
//   strobes qualified by hit; the slave is always ready. A read returns
//   data combinationally in the same cycle; a write takes effect on every
//   rising edge where write & hit is high, so holding the strobe simply
//   re-writes the same value.
interface mmio_timer_if #(
  parameter int adlines   = 8,
  parameter int datalines = 16
);
  logic [adlines-1:0]   address;
  logic [datalines-1:0] datain;
  logic [datalines-1:0] dataout;
  logic                 read;
  logic                 write;
  logic                 hit;
  logic                 irq;

  modport master (
    output address, datain, read, write,
    input  dataout, hit, irq
  );

  modport slave (
    input  address, datain, read, write,
    output dataout, hit, irq
  );
endinterface

// File: rtl/mmio_timer_prescaler.sv
// prescaler
//   Divides the system clock down to the timer tick rate.
//   Ports:
//     clk    - system clock
//     reset  - asynchronous active-high reset
//     run    - count while high, held at 0 while low
//     tick   - one-cycle pulse in the cycle the counter wraps
//   With run rising after an edge, tick is high in the cycle before the
//   PRESCALE-th following edge, so the tick is consumed on that edge.
module prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer
//   Memory-mapped down-counter timer sharing the CPU memory bus with RAM.
//   Ports:
//     clk    - system clock, all state changes on the rising edge
//     reset  - asynchronous active-high reset
//     bus    - mmio_timer_if.slave: address/datain/read/write in,
//              dataout/hit/irq out
//   Registers (offset from BASE): 0 CTRL {irqen,autoreload,en},
//   1 LOAD, 2 COUNT (read-only), 3 STATUS {expired} write-1-to-clear.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int               adlines   = 8,
  parameter int               datalines = 16,
  parameter logic [adlines-1:0] BASE    = adlines'(DEFAULT_BASE),
  parameter int               PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  mmio_timer_if.slave bus
);

  logic [CTRL_W-1:0]    r_ctrl;
  logic [datalines-1:0] r_load;
  logic [datalines-1:0] r_count;
  logic                 r_expired;

  logic                 w_hit;
  logic [1:0]           w_off;
  logic                 w_wr;
  logic                 w_tick;
  logic                 w_expire;
  logic [datalines-1:0] w_rdata;

  // BASE is 4-aligned, so a window match is just the upper address bits.
  assign w_hit = (bus.address[adlines-1:2] == BASE[adlines-1:2]);
  assign w_off = bus.address[1:0];
  assign w_wr  = bus.write & w_hit;

  // The tick is gated by the pre-edge en, so a CTRL write on the same edge
  // never affects the tick being consumed.
  prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (r_ctrl[CTRL_EN]),
    .tick  (w_tick)
  );

  assign w_expire = w_tick && (r_count == '0);

  // Hardware tick handling first, bus writes second: a later assignment in
  // this block wins, which gives LOAD and CTRL writes priority over the
  // tick. The STATUS clear is explicitly masked by a same-edge expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_load    <= '0;
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      if (w_tick) begin
        if (r_count != '0) begin
          r_count <= r_count - 1'b1;
        end else begin
          r_expired <= 1'b1;
          if (r_ctrl[CTRL_AUTORELOAD]) begin
            r_count <= r_load;
          end else begin
            r_ctrl[CTRL_EN] <= 1'b0;
          end
        end
      end

      if (w_wr) begin
        case (w_off)
          OFF_CTRL: r_ctrl <= bus.datain[CTRL_W-1:0];
          OFF_LOAD: begin
            r_load  <= bus.datain;
            r_count <= bus.datain;
          end
          OFF_STATUS: begin
            if (bus.datain[STATUS_EXPIRED] && !w_expire) begin
              r_expired <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_CTRL:   w_rdata = {{(datalines-CTRL_W){1'b0}}, r_ctrl};
      OFF_LOAD:   w_rdata = r_load;
      OFF_COUNT:  w_rdata = r_count;
      OFF_STATUS: w_rdata = {{(datalines-1){1'b0}}, r_expired};
      default:    w_rdata = '0;
    endcase
  end

  assign bus.dataout = (bus.read && w_hit) ? w_rdata : '0;
  assign bus.hit     = w_hit;
  assign bus.irq     = r_expired & r_ctrl[CTRL_IRQEN];

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer
//   Directed bench for mmio_timer (PRESCALE=4, BASE=F0): a table of
//   register read/write vectors plus hand-written multi-cycle sequences.
module tb_mmio_timer;

  localparam logic [7:0] A_CTRL   = 8'hF0;
  localparam logic [7:0] A_LOAD   = 8'hF1;
  localparam logic [7:0] A_COUNT  = 8'hF2;
  localparam logic [7:0] A_STATUS = 8'hF3;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;

  mmio_timer_if #(.adlines(8), .datalines(16)) bus ();

  mmio_timer #(
    .adlines   (8),
    .datalines (16),
    .BASE      (8'hF0),
    .PRESCALE  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a;
    bus.datain  = d;
    bus.write   = 1'b1;
    @(posedge clk);
    #1;
    bus.write   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d, output logic h);
    bus.address = a;
    bus.read    = 1'b1;
    #1;
    d = bus.dataout;
    h = bus.hit;
    bus.read    = 1'b0;
  endtask

  // Returns 1 ns after the posedge that makes cyc reach target.
  task automatic wait_edge(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [15:0] data;
    bit          exp_hit;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] d;
    logic        h;
    int          e;

    cyc   = 0;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.address = '0;
    bus.datain  = '0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;

    // Reset state of outputs while reset is held
    #3;
    check("irq_in_reset", {15'd0, bus.irq}, 16'd0);
    check("dataout_in_reset", bus.dataout, 16'd0);
    #14;
    reset = 1'b0;

    // Table: post-reset reads, window decode, register readback
    vecs.push_back('{1'b0, 8'hF0, 16'h0000, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 8'hF1, 16'h0000, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 8'hF2, 16'h0000, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 8'hF3, 16'h0000, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 8'hEF, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 8'hF4, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{1'b1, 8'hF0, 16'hFFF6, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 8'hF0, 16'h0000, 1'b1, 16'h0006});
    vecs.push_back('{1'b1, 8'hF1, 16'hABCD, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 8'hF1, 16'h0000, 1'b1, 16'hABCD});
    vecs.push_back('{1'b0, 8'hF2, 16'h0000, 1'b1, 16'hABCD});
    vecs.push_back('{1'b1, 8'hF2, 16'h1234, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 8'hF2, 16'h0000, 1'b1, 16'hABCD});
    vecs.push_back('{1'b1, 8'hF3, 16'h0001, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 8'hF3, 16'h0000, 1'b1, 16'h0000});
    vecs.push_back('{1'b1, 8'hEF, 16'h5555, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 8'hF1, 16'h0000, 1'b1, 16'hABCD});
    vecs.push_back('{1'b0, 8'hF0, 16'h0000, 1'b1, 16'h0006});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        rd(vecs[i].addr, d, h);
        check($sformatf("vec%0d_hit", i), {15'd0, h}, {15'd0, vecs[i].exp_hit});
        check($sformatf("vec%0d_data", i), d, vecs[i].exp);
      end
    end

    // One-shot: LOAD=3, CTRL=irqen|en, expiry on edge 16
    pulse_reset();
    wr(A_LOAD, 16'd3);
    wr(A_CTRL, 16'h0005);
    e = cyc;
    for (int k = 1; k <= 16; k++) begin
      wait_edge(e + k);
      rd(A_COUNT, d, h);
      check($sformatf("oneshot_count_k%0d", k), d, (k < 12) ? 16'(3 - k / 4) : 16'd0);
      if (k >= 15) begin
        rd(A_STATUS, d, h);
        check($sformatf("oneshot_expired_k%0d", k), d, (k == 16) ? 16'd1 : 16'd0);
        check($sformatf("oneshot_irq_k%0d", k), {15'd0, bus.irq}, (k == 16) ? 16'd1 : 16'd0);
      end
    end
    rd(A_CTRL, d, h);
    check("oneshot_ctrl_en_cleared", d, 16'h0004);

    // Asynchronous reset mid-count (expired still set, so irq is high)
    wr(A_LOAD, 16'd9);
    wr(A_CTRL, 16'h0005);
    e = cyc;
    wait_edge(e + 2);
    rd(A_COUNT, d, h);
    check("midreset_count_before", d, 16'd9);
    check("midreset_irq_before", {15'd0, bus.irq}, 16'd1);
    #1;
    reset = 1'b1;
    #1;
    rd(A_COUNT, d, h);
    check("midreset_count", d, 16'd0);
    rd(A_CTRL, d, h);
    check("midreset_ctrl", d, 16'd0);
    check("midreset_irq", {15'd0, bus.irq}, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // LOAD write on the same edge as a tick with COUNT=5
    wr(A_LOAD, 16'd5);
    wr(A_CTRL, 16'h0001);
    e = cyc;
    wait_edge(e + 3);
    rd(A_COUNT, d, h);
    check("loadtick_count_pre", d, 16'd5);
    wr(A_LOAD, 16'd7);
    rd(A_COUNT, d, h);
    check("loadtick_count", d, 16'd7);
    wait_edge(e + 8);
    rd(A_COUNT, d, h);
    check("loadtick_next_tick", d, 16'd6);

    // Autoreload: LOAD=2, CTRL=autoreload|en, period 12
    pulse_reset();
    wr(A_LOAD, 16'd2);
    wr(A_CTRL, 16'h0003);
    e = cyc;
    wait_edge(e + 11);
    rd(A_STATUS, d, h);
    check("auto_expired_e11", d, 16'd0);
    wait_edge(e + 12);
    rd(A_STATUS, d, h);
    check("auto_expired_e12", d, 16'd1);
    rd(A_COUNT, d, h);
    check("auto_reload_e12", d, 16'd2);
    rd(A_CTRL, d, h);
    check("auto_en_kept", d, 16'h0003);
    check("auto_irq_masked", {15'd0, bus.irq}, 16'd0);
    wr(A_STATUS, 16'h0001);
    rd(A_STATUS, d, h);
    check("auto_w1c", d, 16'd0);
    wait_edge(e + 23);
    rd(A_STATUS, d, h);
    check("auto_expired_e23", d, 16'd0);
    wait_edge(e + 24);
    rd(A_STATUS, d, h);
    check("auto_expired_e24", d, 16'd1);
    rd(A_COUNT, d, h);
    check("auto_reload_e24", d, 16'd2);
    wr(A_STATUS, 16'h0001);
    wait_edge(e + 35);
    rd(A_STATUS, d, h);
    check("auto_expired_e35", d, 16'd0);
    wr(A_STATUS, 16'h0001);   // lands on edge e+36, the expiry edge
    rd(A_STATUS, d, h);
    check("w1c_vs_expiry", d, 16'd1);

    // read and write together: read sees the pre-edge value
    @(negedge clk);
    bus.address = A_LOAD;
    bus.datain  = 16'h0055;
    bus.read    = 1'b1;
    bus.write   = 1'b1;
    #1;
    check("rw_pre_edge", bus.dataout, 16'd2);
    @(posedge clk);
    #1;
    check("rw_post_edge", bus.dataout, 16'h0055);
    bus.read  = 1'b0;
    bus.write = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped down-counter timer that responds to the CPU's memory bus. It sits beside the RAM block on the same address, read, write and data lines. The control unit programs it with ordinary load/store cycles at a fixed base address. It raises an interrupt-style flag on expiry, and the top level muxes its read data with the RAM's whenever `hit` is asserted.

## Interface
Parameters:
- `adlines`, 8: address bus width; the same value the CPU and RAM use.
- `datalines`, 16: data bus width.
- `BASE`, 8'hF0: first of 4 consecutive register addresses. Must be 4-aligned.
- `PRESCALE`, 4: clocks per counter tick, ≥1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  adlines  bus address from the CU.
- `datain`  in  datalines  write data from the CU (the CU's `toram`).
- `dataout`  out  datalines  read data to the CU; the top muxes it into `fromram`.
- `read`  in  1  bus read strobe (level).
- `write`  in  1  bus write strobe (level).
- `hit`  out  1  address lies in BASE..BASE+3.
- `irq`  out  1  `STATUS.expired & CTRL.irqen`.

## Operation
- Register map (offset = address − BASE):
  - 0 CTRL (rw): bit0 `en`, bit1 `autoreload`, bit2 `irqen`; the other bits read 0.
  - 1 LOAD (rw).
  - 2 COUNT (ro); writes are ignored.
  - 3 STATUS: bit0 `expired`. Write 1 to clear that bit; writing 0 has no effect.
- Read: combinational. `dataout` = selected register when `read & hit`, else 0.
- Write: on each rising edge where `write & hit` is high, the addressed register updates.
  - A strobe held for several cycles re-writes the same value, which is harmless.
  - A write to LOAD also copies `datain` into COUNT.
- Prescaler: counts 0..PRESCALE−1 while `en`=1 and emits a one-cycle tick on wrap. It is held at 0 while `en`=0.
- Tick handling:
  - COUNT>0: COUNT decrements by 1.
  - COUNT==0: `expired` sets to 1.
    - `autoreload`=1: COUNT reloads from LOAD.
    - `autoreload`=0: COUNT stays 0 and `en` clears.
- Counter arithmetic is unsigned, datalines wide, and never underflows.
- Simultaneous events, resolved in the same edge:
  - Expiry and a STATUS write-1-to-clear: expiry wins, so `expired` stays 1.
  - A LOAD write and a tick: the LOAD write wins and COUNT = `datain`.
  - A CTRL write and a tick: the tick uses the pre-write `en`. The CTRL write then overrides any hardware clear of `en`.
  - `read` and `write` both high: the read returns the pre-edge value and the write still happens.

## Timing
- Reset values: CTRL=0, LOAD=0, COUNT=0, STATUS=0, prescaler=0. Outputs `dataout`=0, `hit` is combinational, `irq`=0.
- Reset is asynchronous. Asserting it mid-count clears everything immediately; no partial tick survives.
- Read latency is 0 cycles. A written value is visible to reads from the cycle after the write edge.
- After setting `en` with COUNT=N, the first tick comes PRESCALE edges later.
- `expired` sets on edge (N+1)·PRESCALE after `en` rises. `irq` follows in the same cycle.
- With autoreload, the period is (LOAD+1)·PRESCALE clocks.

## Structure
- Shared package, alongside the existing parameters include: register offsets (`OFF_CTRL`, `OFF_LOAD`, `OFF_COUNT`, `OFF_STATUS`), CTRL bit indices, and the default BASE.
- Sub-module `prescaler` (parameter PRESCALE; ports `clk`, `reset`, `run`, `tick`).
- Everything else lives in one always block for registers and one combinational read mux.

## Test plan
- Reset then read all 4 offsets → each returns 0; `hit`=1 only for F0..F3, `hit`=0 for 0xEF and 0xF4.
- LOAD=3, CTRL=3'b101, PRESCALE=4 → COUNT steps 3,2,1,0 every 4 clocks; `expired` and `irq` rise at edge 16; `en` reads 0 afterwards.
- LOAD=2, CTRL=3'b011 → `expired` sets every 12 clocks and COUNT reloads to 2; a W1C to STATUS between expiries clears it.
- W1C to STATUS on the exact expiry edge → `expired` reads 1 afterwards.
- Write LOAD=7 on the same edge as a tick with COUNT=5 → COUNT reads 7, not 4.
- Assert `reset` mid-count with COUNT=9 → COUNT, CTRL and `irq` are 0 without waiting for a clock edge.
